// File: rtl/permute_expand24.sv
// Expands one 7-variable truth table into one beat per set mask bit, permuting variables 3..6 per beat.
// First beat 1 cycle after accept, then 1 beat/cycle; stalls hold all outputs; next job accepted on the last transfer.
module permute_expand24 (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inBot,
    input  logic [23:0]  inMask,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outBot,
    output logic [4:0]   outIndex,
    output logic         outLast
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [1:0] A = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] C = 2'd2;
    localparam logic [1:0] D = 2'd3;

    state_t        state, stateNext;
    logic [127:0]  bot, botNext;
    logic [23:0]   remMask, remMaskNext;
    logic [4:0]    topIdx;

    // Letter codes packed {L3,L2,L1,L0}; A..D map to variables 3..6.
    function automatic logic [7:0] patternOf(input logic [4:0] pos);
        case (pos)
            5'd23:   patternOf = {D, C, B, A};
            5'd22:   patternOf = {C, D, B, A};
            5'd21:   patternOf = {D, B, C, A};
            5'd20:   patternOf = {B, D, C, A};
            5'd19:   patternOf = {C, B, D, A};
            5'd18:   patternOf = {B, C, D, A};
            5'd17:   patternOf = {D, C, A, B};
            5'd16:   patternOf = {C, D, A, B};
            5'd15:   patternOf = {D, A, C, B};
            5'd14:   patternOf = {A, D, C, B};
            5'd13:   patternOf = {C, A, D, B};
            5'd12:   patternOf = {A, C, D, B};
            5'd11:   patternOf = {D, A, B, C};
            5'd10:   patternOf = {A, D, B, C};
            5'd9:    patternOf = {D, B, A, C};
            5'd8:    patternOf = {B, D, A, C};
            5'd7:    patternOf = {A, B, D, C};
            5'd6:    patternOf = {B, A, D, C};
            5'd5:    patternOf = {A, C, B, D};
            5'd4:    patternOf = {C, A, B, D};
            5'd3:    patternOf = {A, B, C, D};
            5'd2:    patternOf = {B, A, C, D};
            5'd1:    patternOf = {C, B, A, D};
            5'd0:    patternOf = {B, C, A, D};
            default: patternOf = {D, C, B, A};
        endcase
    endfunction

    // Output assignment i reads source assignment j, where j bit 3+p takes i's bit of variable Lp.
    function automatic logic [127:0] permute(input logic [127:0] src, input logic [7:0] pat);
        logic [127:0] res;
        logic [6:0]   iv;
        logic [6:0]   jv;
        logic [1:0]   letter;
        res = '0;
        for (int i = 0; i < 128; i++) begin
            iv = 7'(i);
            jv = iv;
            for (int p = 0; p < 4; p++) begin
                letter = pat[2*p +: 2];
                jv[3+p] = iv[{1'b0, letter} + 3'd3];
            end
            res[i] = src[jv];
        end
        return res;
    endfunction

    always_comb begin
        topIdx = 5'd0;
        for (int k = 0; k < 24; k++) begin
            if (remMask[k]) topIdx = 5'(k);
        end
    end

    assign outValid = (state == EMIT);
    assign outIndex = topIdx;
    assign outLast  = (remMask != 24'd0) && ((remMask & (remMask - 24'd1)) == 24'd0);
    assign outBot   = permute(bot, patternOf(topIdx));

    always_comb begin
        stateNext   = state;
        botNext     = bot;
        remMaskNext = remMask;
        inReady     = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    botNext     = inBot;
                    remMaskNext = inMask;
                    stateNext   = (inMask != 24'd0) ? EMIT : IDLE;
                end
            end
            EMIT: begin
                inReady = outReady & outLast;
                if (outReady) begin
                    remMaskNext = remMask & ~(24'd1 << topIdx);
                    if (outLast) begin
                        if (inValid) begin
                            botNext     = inBot;
                            remMaskNext = inMask;
                            stateNext   = (inMask != 24'd0) ? EMIT : IDLE;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bot     <= '0;
            remMask <= '0;
        end else begin
            state   <= stateNext;
            bot     <= botNext;
            remMask <= remMaskNext;
        end
    end

endmodule

// File: tb/tb_permute_expand24.sv
// Randomized bench for permute_expand24 with a string-table reference model and per-cycle scoreboard.
module tb_permute_expand24;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [127:0] inBot = '0;
    logic [23:0]  inMask = '0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [127:0] outBot;
    logic [4:0]   outIndex;
    logic         outLast;

    int checks = 0;
    int errors = 0;
    int readyMode = 0;   // 0: always ready, 1: random, 2: driven by main sequence

    int           qIdx[$];
    logic [127:0] qBot[$];
    bit           qLast[$];

    string pats[24] = '{"ABCD", "ABDC", "ACBD", "ACDB", "ADBC", "ADCB",
                        "BACD", "BADC", "BCAD", "BCDA", "BDAC", "BDCA",
                        "CBAD", "CBDA", "CABD", "CADB", "CDBA", "CDAB",
                        "DBCA", "DBAC", "DCBA", "DCAB", "DABC", "DACB"};

    permute_expand24 dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inBot(inBot), .inMask(inMask),
        .outValid(outValid), .outReady(outReady), .outBot(outBot),
        .outIndex(outIndex), .outLast(outLast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] refPerm(input logic [127:0] b, input int pos);
        string pat;
        logic [127:0] r;
        int j;
        int v;
        pat = pats[23 - pos];
        r = '0;
        for (int i = 0; i < 128; i++) begin
            j = i % 8;
            for (int p = 0; p < 4; p++) begin
                v = 3 + (pat[p] - "A");
                j += ((i >> v) & 1) << (3 + p);
            end
            r[i] = b[j];
        end
        return r;
    endfunction

    task automatic pushJob(input logic [127:0] b, input logic [23:0] m);
        for (int pos = 23; pos >= 0; pos--) begin
            if (m[pos]) begin
                qIdx.push_back(pos);
                qBot.push_back(refPerm(b, pos));
                qLast.push_back((m & ((24'd1 << pos) - 24'd1)) == 24'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            qIdx.delete(); qBot.delete(); qLast.delete();
        end else begin
            chk("outValid", outValid, qIdx.size() != 0);
            chk("inReady", inReady, (qIdx.size() == 0) || (outReady && qIdx.size() == 1));
            if (outValid && qIdx.size() != 0) begin
                chk("beatIndex", outIndex, qIdx[0]);
                chk("beatBot", outBot, qBot[0]);
                chk("beatLast", outLast, qLast[0]);
                if (outReady) begin
                    void'(qIdx.pop_front()); void'(qBot.pop_front()); void'(qLast.pop_front());
                end
            end
            if (inValid && inReady) pushJob(inBot, inMask);
        end
    end

    always @(posedge clk) begin
        #1;
        if (readyMode == 0) outReady = 1'b1;
        else if (readyMode == 1) outReady = 1'($urandom_range(0, 1));
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic sendJob(input logic [127:0] b, input logic [23:0] m, output int waited);
        inValid = 1'b1; inBot = b; inMask = m; waited = 0;
        @(negedge clk);
        while (!inReady && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!inReady) chk("acceptTimeout", 0, 1);
        @(posedge clk); #1;
        inValid = 1'b0; inBot = rnd128(); inMask = 24'($urandom);
    endtask

    initial begin
        int w;
        int rp[5] = '{0, 1, 0, 0, 1};
        int ei[5] = '{2, 2, 0, 0, 0};
        logic [23:0] m;

        #1 rst = 1'b1;
        #2;
        chk("rstOutValid", outValid, 0);
        chk("rstInReady", inReady, 1);
        chk("rstOutBot", outBot, 0);
        chk("rstOutIndex", outIndex, 0);
        chk("rstOutLast", outLast, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        sendJob(128'h100, 24'h800000, w);
        @(negedge clk);
        chk("abcdIndex", outIndex, 23);
        chk("abcdBot", outBot, 128'h100);
        chk("abcdLast", outLast, 1);
        @(posedge clk); #1;

        sendJob(128'h100, 24'h020000, w);
        @(negedge clk);
        chk("bacdIndex", outIndex, 17);
        chk("bacdBot", outBot, 128'h10000);
        chk("bacdLast", outLast, 1);
        @(posedge clk); #1;

        sendJob(rnd128(), 24'hFFFFFF, w);
        for (int k = 23; k >= 0; k--) begin
            @(negedge clk);
            chk("fullValid", outValid, 1);
            chk("fullIndex", outIndex, k);
            chk("fullLast", outLast, k == 0);
        end
        @(posedge clk); #1;

        sendJob(rnd128(), 24'h0, w);
        @(negedge clk);
        chk("zeroNoValid", outValid, 0);
        chk("zeroInReady", inReady, 1);
        @(posedge clk); #1;
        sendJob(rnd128(), 24'h000001, w);
        @(negedge clk);
        chk("afterZeroValid", outValid, 1);
        chk("afterZeroIndex", outIndex, 0);
        @(posedge clk); #1;

        readyMode = 2;
        outReady = 1'b0;
        sendJob(rnd128(), 24'h000005, w);
        for (int k = 0; k < 5; k++) begin
            outReady = rp[k][0];
            if (k == 4) begin
                inValid = 1'b1; inBot = rnd128(); inMask = 24'h000300;
            end
            @(negedge clk);
            chk("stallValid", outValid, 1);
            chk("stallIndex", outIndex, ei[k]);
            if (k == 4) chk("acceptOnLast", inReady, 1);
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        chk("job2Valid", outValid, 1);
        chk("job2Index", outIndex, 9);
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;

        sendJob(rnd128(), 24'hFFFFFF, w);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midRstValid", outValid, 0);
        chk("midRstInReady", inReady, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk("noOldBeat", outValid, 0);
        end
        @(posedge clk); #1;

        readyMode = 1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: m = 24'h0;
                1: m = 24'd1 << $urandom_range(0, 23);
                2: m = 24'($urandom);
                default: m = 24'hFFFFFF;
            endcase
            sendJob(rnd128(), m, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        readyMode = 0;
        for (int t = 0; t < 100 && qIdx.size() != 0; t++) @(negedge clk);
        chk("drainEmpty", qIdx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
